// File: rtl/hilo_muldiv_ctrl_pkg.sv
// hilo_muldiv_ctrl_pkg: shared HI/LO op encodings, sequencer states and divide iteration count
package hilo_muldiv_ctrl_pkg;
  typedef enum logic [2:0] {
    HILO_NOP,
    HILO_MULT,
    HILO_MULTU,
    HILO_DIV,
    HILO_DIVU,
    HILO_MTHI,
    HILO_MTLO
  } hilo_op_t;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  localparam int DIV_ITERS = 32;
endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter_core.sv
// hilo_muldiv_ctrl_div_iter_core: radix-2 restoring divide on magnitudes (clk, rst, load, step, dividend, divisor -> quotient, remainder), one quotient bit per step, MSB first
module hilo_muldiv_ctrl_div_iter_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  logic [31:0] dvs;
  logic [32:0] t, d;
  assign t = {remainder, quotient[31]};
  assign d = t - {1'b0, dvs};
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs       <= divisor;
    end else if (step) begin
      quotient  <= {quotient[30:0], ~d[32]};
      remainder <= d[32] ? t[31:0] : d[31:0];
    end
  end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO mul/div sequencer (clk, rst, start, op, src_a, src_b, flush -> stall, low_we, high_we, low_wdata, high_wdata)
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        low_we,
  output logic        high_we,
  output logic [31:0] low_wdata,
  output logic [31:0] high_wdata
);
  state_t      state;
  logic [4:0]  cnt;
  logic        is_div, neg_q, neg_r, b_zero;
  logic [31:0] a_raw, mag_a, mag_b, quo, rem;
  logic        accept, op_div, op_signed, sa, sb, mt_hi, mt_lo, done_we;
  logic [31:0] ma, mb, q_fix, r_fix;
  logic [63:0] prod_u, prod;
  assign op_div    = op == HILO_DIV || op == HILO_DIVU;
  assign op_signed = op == HILO_MULT || op == HILO_DIV;
  assign accept    = state == S_IDLE && start && !flush && op >= HILO_MULT && op <= HILO_DIVU;
  assign mt_hi     = state == S_IDLE && start && !flush && op == HILO_MTHI;
  assign mt_lo     = state == S_IDLE && start && !flush && op == HILO_MTLO;
  assign sa        = op_signed & src_a[31];
  assign sb        = op_signed & src_b[31];
  assign ma        = sa ? -src_a : src_a;
  assign mb        = sb ? -src_b : src_b;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
    end else if (accept) begin
      state  <= S_BUSY;
      cnt    <= op_div ? 5'(DIV_ITERS - 1) : 5'(MUL_LAT - 1);
      is_div <= op_div;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      b_zero <= src_b == '0;
      a_raw  <= src_a;
      mag_a  <= ma;
      mag_b  <= mb;
    end else if (state == S_BUSY) begin
      state <= flush ? S_IDLE : cnt == '0 ? S_DONE : S_BUSY;
      cnt   <= flush || cnt == '0 ? '0 : cnt - 5'd1;
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end
  hilo_muldiv_ctrl_div_iter_core u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (state == S_BUSY),
    .dividend  (ma),
    .divisor   (mb),
    .quotient  (quo),
    .remainder (rem)
  );
  // Divide-by-zero bypasses the sign fix-up so HI returns the raw dividend
  assign q_fix   = b_zero ? '1 : neg_q ? -quo : quo;
  assign r_fix   = b_zero ? a_raw : neg_r ? -rem : rem;
  assign prod_u  = {32'b0, mag_a} * {32'b0, mag_b};
  assign prod    = neg_q ? -prod_u : prod_u;
  assign done_we = state == S_DONE && !flush;
  assign stall   = accept || (state == S_BUSY && !flush);
  assign high_we = done_we || mt_hi;
  assign low_we  = done_we || mt_lo;
  assign high_wdata = mt_hi ? src_a : done_we ? (is_div ? r_fix : prod[63:32]) : '0;
  assign low_wdata  = mt_lo ? src_a : done_we ? (is_div ? q_fix : prod[31:0]) : '0;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: randomized self-checking bench against an arithmetic HI/LO reference model
module tb_hilo_muldiv_ctrl;
  localparam int MUL_LAT = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        stall, low_we, high_we;
  logic [31:0] low_wdata, high_wdata;
  int          tests = 0;
  int          fails = 0;
  int          nstall, wcycle, nwe, stall_at_we;
  logic [31:0] got_hi, got_lo;
  always #5 clk = ~clk;
  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .stall      (stall),
    .low_we     (low_we),
    .high_we    (high_we),
    .low_wdata  (low_wdata),
    .high_wdata (high_wdata)
  );
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q, r;
    if (o == 3'd1) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
    end
    if (o == 3'd2) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (o == 3'd3) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction
  function automatic int lat(input logic [2:0] o);
    return (o == 3'd3 || o == 3'd4) ? 32 : MUL_LAT;
  endfunction
  // Called just after a rising edge; issues one command, optionally holding start while stalled like EX does
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic hold);
    logic s;
    start = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0;
    nstall = 0; wcycle = -1; nwe = 0; stall_at_we = -1; got_hi = '0; got_lo = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      s = stall;
      if (stall) nstall++;
      if (low_we || high_we) begin
        nwe++;
        if (wcycle < 0) begin
          wcycle = c; got_hi = high_wdata; got_lo = low_wdata; stall_at_we = int'(stall);
        end
      end
      @(posedge clk);
      #1 start = hold && s;
    end
    start = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if ({stall, low_we, high_we, low_wdata, high_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got stall=%b lwe=%b hwe=%b lo=%h hi=%h want all 0", stall, low_we, high_we, low_wdata, high_wdata);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_cmd(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic hold);
    logic [63:0] exp;
    exp = model(o, a, b);
    do_op(o, a, b, hold);
    tests++;
    if (nstall !== lat(o) + 1 || wcycle !== lat(o) + 1 || nwe !== 1 || stall_at_we !== 0) begin
      fails++;
      $display("FAIL %s_timing got stall_cycles=%0d write_cycle=%0d writes=%0d stall_at_we=%0d want %0d %0d 1 0", name, nstall, wcycle, nwe, stall_at_we, lat(o) + 1, lat(o) + 1);
    end
    tests++;
    if ({got_hi, got_lo} !== exp) begin
      fails++;
      $display("FAIL %s_data op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", name, o, a, b, got_hi, got_lo, exp[63:32], exp[31:0]);
    end
  endtask
  task automatic test_directed;
    test_cmd("mult_neg3x5", 3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    test_cmd("div_7_neg2", 3'd3, 32'd7, 32'hFFFF_FFFE, 1'b1);
    test_cmd("divu_max_16", 3'd4, 32'hFFFF_FFFF, 32'h10, 1'b0);
    test_cmd("divu_by_zero", 3'd4, 32'h8000_0000, 32'd0, 1'b0);
    test_cmd("div_neg_by_zero", 3'd3, 32'hFFFF_FFF0, 32'd0, 1'b1);
    test_cmd("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    test_cmd("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    test_cmd("mult_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
  endtask
  task automatic test_mt;
    start = 1'b1; op = 3'd5; src_a = 32'h1234_5678;
    @(negedge clk);
    tests++;
    if ({high_we, low_we, stall} !== 3'b100 || high_wdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL mthi got hwe=%b lwe=%b stall=%b hi=%h want 1 0 0 12345678", high_we, low_we, stall, high_wdata);
    end
    flush = 1'b1;
    #1;
    tests++;
    if ({high_we, low_we, stall} !== 3'b000) begin
      fails++;
      $display("FAIL mthi_flush got hwe=%b lwe=%b stall=%b want 0 0 0", high_we, low_we, stall);
    end
    flush = 1'b0; op = 3'd6; src_a = 32'hCAFE_0001;
    #1;
    tests++;
    if ({high_we, low_we, stall} !== 3'b010 || low_wdata !== 32'hCAFE_0001 || high_wdata !== 32'h0) begin
      fails++;
      $display("FAIL mtlo got hwe=%b lwe=%b stall=%b lo=%h hi=%h want 0 1 0 cafe0001 0", high_we, low_we, stall, low_wdata, high_wdata);
    end
    for (int k = 0; k < 2; k++) begin
      op = k == 0 ? 3'd0 : 3'd7;
      @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if ({high_we, low_we, stall} !== 3'b000) begin
        fails++;
        $display("FAIL nop_op%0d got hwe=%b lwe=%b stall=%b want 0 0 0", op, high_we, low_we, stall);
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic test_flush;
    int bad = 0;
    start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    tests++;
    if ({stall, low_we, high_we} !== 3'b000) begin
      fails++;
      $display("FAIL flush_busy got stall=%b lwe=%b hwe=%b want 0 0 0", stall, low_we, high_we);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    test_cmd("multu_after_flush", 3'd2, 32'd2, 32'd3, 1'b0);
    start = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (stall || low_we || high_we) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL flush_with_start got %0d active cycles want 0", bad);
    end
    start = 1'b1; op = 3'd2; src_a = 32'd4; src_b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    tests++;
    if ({low_we, high_we, stall} !== 3'b000) begin
      fails++;
      $display("FAIL flush_done got lwe=%b hwe=%b stall=%b want 0 0 0", low_we, high_we, stall);
    end
    @(posedge clk);
    #1 flush = 1'b0;
  endtask
  task automatic test_rst_mid;
    int bad = 0;
    start = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF; src_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ({stall, low_we, high_we, low_wdata, high_wdata} !== '0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL rst_mid_divide got %0d non-idle cycles want 0", bad);
    end
    @(posedge clk);
    #1;
    test_cmd("divu_after_rst", 3'd4, 32'd100, 32'd7, 1'b0);
  endtask
  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int n = 0; n < 30; n++) begin
      o = 3'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = '0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 4) == 0) b = -b;
      test_cmd("random", o, a, b, 1'($urandom_range(0, 1)));
    end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_mt;
    test_flush;
    test_rst_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
